prbs_gen_chk: RTL and testbench

Parametrised pseudo-random bit-sequence generator and self-synchronising checker for link and loopback testing. Generalises the fixed single-bit PRBS31 block: polynomial is run-time selectable (PRBS7/15/23/31), W bits are produced and checked per clock, and the checker locks, counts bit errors and detects loss of lock. The generator output is driven to the pad side, and the checker consumes the looped-back or received stream.

---
 rtl/prbs_pkg.sv | 43 ++++
 rtl/prbs_gen_chk_if.sv | 24 ++
 rtl/prbs_step.sv | 33 +++
 rtl/prbs_gen_chk.sv | 248 ++++++++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and tap constants for the PRBS generator/checker.
// Polynomial encoding, checker FSM states and tap lookup.
package prbs_pkg;

    typedef enum logic [1:0] {
        POLY_7  = 2'd0,
        POLY_15 = 2'd1,
        POLY_23 = 2'd2,
        POLY_31 = 2'd3
    } poly_e;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_st_e;

    typedef struct packed {
        logic [4:0] n;
        logic [4:0] t;
    } tap_t;

    localparam logic [4:0] N7  = 5'd7;
    localparam logic [4:0] T7  = 5'd6;
    localparam logic [4:0] N15 = 5'd15;
    localparam logic [4:0] T15 = 5'd14;
    localparam logic [4:0] N23 = 5'd23;
    localparam logic [4:0] T23 = 5'd18;
    localparam logic [4:0] N31 = 5'd31;
    localparam logic [4:0] T31 = 5'd28;

    function automatic tap_t taps(input poly_e p);
        tap_t r;
        unique case (p)
            POLY_7:  r = '{n: N7,  t: T7};
            POLY_15: r = '{n: N15, t: T15};
            POLY_23: r = '{n: N23, t: T23};
            POLY_31: r = '{n: N31, t: T31};
            default: r = '{n: N7,  t: T7};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if: generated and received data words with their valids.
// master = PRBS block, slave = link/loopback side.
interface prbs_gen_chk_if #(
    parameter int W = 1
);
    logic [W-1:0] gen_data;
    logic         gen_valid;
    logic [W-1:0] chk_data;
    logic         chk_valid;

    modport master (
        output gen_data,
        output gen_valid,
        input  chk_data,
        input  chk_valid
    );

    modport slave (
        input  gen_data,
        input  gen_valid,
        output chk_data,
        output chk_valid
    );
endinterface

// File: rtl/prbs_step.sv
// prbs_step: W combinational steps of a 31-bit Fibonacci LFSR.
// fb_out=0 returns the emitted bits s[N-1]; fb_out=1 returns the feedback bits.
module prbs_step #(
    parameter int W = 1
) (
    input  logic [30:0]  state,
    input  logic [4:0]   n,
    input  logic [4:0]   t,
    input  logic         fb_out,
    output logic [W-1:0] bits,
    output logic [30:0]  nxt
);

    logic [30:0] s;
    logic        ob;
    logic        nb;

    // Unroll W steps; first step lands in bits[W-1]
    always_comb begin
        s    = state;
        ob   = 1'b0;
        nb   = 1'b0;
        bits = '0;
        for (int i = 0; i < W; i++) begin
            ob = s[n - 5'd1];
            nb = ob ^ s[t - 5'd1];
            bits[W-1-i] = fb_out ? nb : ob;
            s = {s[29:0], nb};
        end
        nxt = s;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS7/15/23/31 generator and self-synchronising checker.
// Optional macro PRBS_ERR_INJECT_EN adds inj_err single-bit error injection.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int W        = 1,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       poly_sel,
    prbs_gen_chk_if.master   bus,
    input  logic             clr_cnt,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
`ifdef PRBS_ERR_INJECT_EN
    ,
    input  logic             inj_err
`endif
);

    localparam int GW   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int BW   = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
    localparam int SUMW = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]   poly_q;
    logic         poly_chg;
    logic         rst_any;
    tap_t         tp;

    logic [30:0]  gs;
    logic [30:0]  gs_nxt;
    logic [W-1:0] g_bits;
    logic [W-1:0] gen_word;
    logic [W-1:0] gen_data_q;
    logic         gen_valid_q;

    logic [30:0]  cs;
    logic [30:0]  cs_nxt;
    logic [30:0]  cs_load;
    logic [W-1:0] pred;
    logic [W-1:0] diff;
    logic [5:0]   pc;
    logic [5:0]   fill_cnt;
    logic [5:0]   fill_n;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    chk_st_e      st;
    chk_st_e      nst;
    logic         filling;
    logic         word_err;
    logic         lock_hit;
    logic         loss_hit;
    logic         flag_nxt;
    logic [SUMW-1:0]  sum;
    logic [CNT_W-1:0] sat;

    assign poly_chg = (poly_sel != poly_q);
    assign rst_any  = rst_n | poly_chg;
    assign tp       = taps(poly_e'(poly_sel));

    assign bus.gen_data  = gen_data_q;
    assign bus.gen_valid = gen_valid_q;

    prbs_step #(.W(W)) u_gen (
        .state  (gs),
        .n      (tp.n),
        .t      (tp.t),
        .fb_out (1'b0),
        .bits   (g_bits),
        .nxt    (gs_nxt)
    );

    prbs_step #(.W(W)) u_chk (
        .state  (cs),
        .n      (tp.n),
        .t      (tp.t),
        .fb_out (1'b1),
        .bits   (pred),
        .nxt    (cs_nxt)
    );

`ifdef PRBS_ERR_INJECT_EN
    logic         inj_q;
    logic         inj_pend;
    logic         inj_now;
    logic [W-1:0] inj_mask;

    assign inj_now = (inj_err & ~inj_q) | inj_pend;

    // Place the pending inversion on the earliest bit of the word
    always_comb begin
        inj_mask      = '0;
        inj_mask[W-1] = inj_now;
    end

    assign gen_word = g_bits ^ inj_mask;

    // Edge detect inj_err; hold the request until a word is generated
    always_ff @(posedge clk) begin
        if (rst_n) begin
            inj_q    <= 1'b0;
            inj_pend <= 1'b0;
        end else begin
            inj_q    <= inj_err;
            inj_pend <= en ? 1'b0 : inj_now;
        end
    end
`else
    assign gen_word = g_bits;
`endif

    // Generator state, output word and poly_sel tracking
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gs          <= 31'd1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            poly_q      <= poly_sel;
        end else if (poly_chg) begin
            gs          <= 31'd1;
            gen_valid_q <= 1'b0;
            poly_q      <= poly_sel;
        end else if (en) begin
            gs          <= gs_nxt;
            gen_data_q  <= gen_word;
            gen_valid_q <= 1'b1;
        end else begin
            gen_valid_q <= 1'b0;
        end
    end

    // Received bits shifted into the checker state, earliest first
    always_comb begin
        cs_load = cs;
        for (int i = 0; i < W; i++) begin
            cs_load = {cs_load[29:0], bus.chk_data[W-1-i]};
        end
    end

    // Words needed to fill N bits of history
    always_comb begin
        fill_n = 6'((32'(tp.n) + 32'(W) - 32'd1) / 32'(W));
    end

    // Per-word error vector and its popcount
    always_comb begin
        diff = pred ^ bus.chk_data;
        pc   = '0;
        for (int i = 0; i < W; i++) begin
            pc = pc + 6'(diff[i]);
        end
    end

    assign word_err = |diff;
    assign filling  = (fill_cnt < fill_n);
    assign lock_hit = !filling && !word_err
                   && (good_cnt == GW'(LOCK_CNT - 1));
    assign loss_hit = word_err
                   && (bad_cnt == BW'(LOSS_CNT - 1));

    // Checker FSM state register
    always_ff @(posedge clk) begin
        if (rst_any) begin
            st <= ST_SEARCH;
        end else begin
            st <= nst;
        end
    end

    // Checker FSM next state
    always_comb begin
        nst = st;
        if (bus.chk_valid) begin
            unique case (st)
                ST_SEARCH: if (lock_hit) nst = ST_LOCKED;
                ST_LOCKED: if (loss_hit) nst = ST_SEARCH;
                default:   nst = st;
            endcase
        end
    end

    // Checker FSM outputs
    always_comb begin
        locked   = (st == ST_LOCKED);
        flag_nxt = bus.chk_valid && (st == ST_LOCKED) && word_err;
    end

    // Checker state, fill and run-length counters
    always_ff @(posedge clk) begin
        if (rst_any) begin
            cs       <= '0;
            fill_cnt <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (bus.chk_valid) begin
            if (st == ST_SEARCH) begin
                cs      <= cs_load;
                bad_cnt <= '0;
                if (filling) begin
                    fill_cnt <= fill_cnt + 6'd1;
                end else if (word_err || lock_hit) begin
                    good_cnt <= '0;
                end else begin
                    good_cnt <= good_cnt + GW'(1);
                end
            end else begin
                cs       <= cs_nxt;
                good_cnt <= '0;
                if (!word_err) begin
                    bad_cnt <= '0;
                end else if (loss_hit) begin
                    bad_cnt  <= '0;
                    fill_cnt <= '0;
                end else begin
                    bad_cnt <= bad_cnt + BW'(1);
                end
            end
        end
    end

    // Saturating add of this word's bit errors
    always_comb begin
        sum = SUMW'(err_cnt) + SUMW'(pc);
        sat = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    // Error counter and flag; clear beats a coincident error
    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            err_flag <= flag_nxt && !poly_chg;
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (flag_nxt && !poly_chg) begin
                err_cnt <= sat;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed checks of the PRBS generator and checker.
// Instance d1 runs W=1 PRBS7; instance d8 runs W=8 with a 4-bit counter.
module tb_prbs_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst1, en1, clr1, inj1;
    logic [1:0]  poly1;
    logic        locked1, flag1;
    logic [15:0] err1;

    logic        rst8, en8, clr8, inj8;
    logic [1:0]  poly8;
    logic        locked8, flag8;
    logic [3:0]  err8;
    logic [7:0]  mask8;

    prbs_gen_chk_if #(.W(1)) b1 ();
    prbs_gen_chk_if #(.W(8)) b8 ();

    assign b1.chk_data  = b1.gen_data;
    assign b1.chk_valid = b1.gen_valid;
    assign b8.chk_data  = b8.gen_data ^ mask8;
    assign b8.chk_valid = b8.gen_valid;

    prbs_gen_chk #(.W(1)) d1 (
        .clk      (clk),
        .rst_n    (rst1),
        .en       (en1),
        .poly_sel (poly1),
        .bus      (b1),
        .clr_cnt  (clr1),
        .locked   (locked1),
        .err_cnt  (err1),
        .err_flag (flag1)
`ifdef PRBS_ERR_INJECT_EN
        ,
        .inj_err  (inj1)
`endif
    );

    prbs_gen_chk #(.W(8), .CNT_W(4)) d8 (
        .clk      (clk),
        .rst_n    (rst8),
        .en       (en8),
        .poly_sel (poly8),
        .bus      (b8),
        .clr_cnt  (clr8),
        .locked   (locked8),
        .err_cnt  (err8),
        .err_flag (flag8)
`ifdef PRBS_ERR_INJECT_EN
        ,
        .inj_err  (inj8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic        bits [0:253];
    logic [13:0] f14;
    int          vbad, pdiff, ones, run, maxrun, bad, pulses;

    initial begin
        rst1 = 1'b1; en1 = 1'b0; poly1 = 2'd0; clr1 = 1'b0; inj1 = 1'b0;
        rst8 = 1'b1; en8 = 1'b0; poly8 = 2'd3; clr8 = 1'b0; inj8 = 1'b0;
        mask8 = 8'h00;
        tick(3);

        chk("rst_gen_data",  32'(b8.gen_data), 32'h0);
        chk("rst_gen_valid", 32'(b8.gen_valid), 32'h0);
        chk("rst_locked",    32'(locked8), 32'h0);
        chk("rst_err_cnt",   32'(err8), 32'h0);
        chk("rst_err_flag",  32'(flag8), 32'h0);
        chk("rst_d1_valid",  32'(b1.gen_valid), 32'h0);

        // PRBS7, W=1: collect two periods
        rst1 = 1'b0;
        en1  = 1'b1;
        vbad = 0;
        for (int k = 0; k < 254; k++) begin
            tick(1);
            bits[k] = b1.gen_data[0];
            if (b1.gen_valid !== 1'b1) vbad++;
        end
        chk("p7_valid", 32'(vbad), 32'h0);
        for (int k = 0; k < 14; k++) f14[13-k] = bits[k];
        chk("p7_first14", 32'(f14), 32'h0083);
        pdiff = 0;
        ones  = 0;
        for (int k = 0; k < 127; k++) begin
            if (bits[k] !== bits[k+127]) pdiff++;
            if (bits[k] === 1'b1) ones++;
        end
        chk("p7_period", 32'(pdiff), 32'h0);
        chk("p7_ones", 32'(ones), 32'd64);
        run    = 0;
        maxrun = 0;
        for (int k = 0; k < 254; k++) begin
            run = (bits[k] === 1'b0) ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("p7_zero_run", 32'(maxrun), 32'd6);
        chk("p7_locked", 32'(locked1), 32'h1);
        chk("p7_err_cnt", 32'(err1), 32'h0);

        // PRBS31, W=8 loopback: fill 4 + lock 8 words
        rst8 = 1'b0;
        en8  = 1'b1;
        tick(12);
        chk("lock_before", 32'(locked8), 32'h0);
        tick(1);
        chk("lock_at_12", 32'(locked8), 32'h1);

        bad = 0;
        repeat (10000) begin
            tick(1);
            if (err8 !== 4'd0 || locked8 !== 1'b1 || flag8 !== 1'b0) bad++;
        end
        chk("clean_run", 32'(bad), 32'h0);

        // single flipped bit
        mask8 = 8'h10;
        tick(1);
        mask8 = 8'h00;
        chk("one_err_cnt", 32'(err8), 32'd1);
        chk("one_err_flag", 32'(flag8), 32'h1);
        chk("one_err_locked", 32'(locked8), 32'h1);
        tick(1);
        chk("one_err_flag_off", 32'(flag8), 32'h0);
        chk("one_err_hold", 32'(err8), 32'd1);

        // four errored words drop lock
        mask8 = 8'h01;
        tick(3);
        chk("loss_3", 32'(locked8), 32'h1);
        tick(1);
        mask8 = 8'h00;
        chk("loss_4", 32'(locked8), 32'h0);
        chk("loss_err_cnt", 32'(err8), 32'd5);
        tick(11);
        chk("relock_before", 32'(locked8), 32'h0);
        tick(1);
        chk("relock_12", 32'(locked8), 32'h1);

        // saturation at 15
        clr8 = 1'b1;
        tick(1);
        clr8 = 1'b0;
        chk("clr", 32'(err8), 32'h0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            mask8 = 8'h80;
            tick(1);
            mask8 = 8'h00;
            if (flag8 === 1'b1) pulses++;
            tick(1);
        end
        chk("sat_15", 32'(err8), 32'd15);
        chk("sat_pulses", 32'(pulses), 32'd20);
        chk("sat_locked", 32'(locked8), 32'h1);

        // clear wins over a coincident error
        mask8 = 8'h02;
        clr8  = 1'b1;
        tick(1);
        mask8 = 8'h00;
        clr8  = 1'b0;
        chk("clr_vs_err_cnt", 32'(err8), 32'h0);
        chk("clr_vs_err_flag", 32'(flag8), 32'h1);

        // poly_sel 3 -> 0 keeps err_cnt, restarts at state 1
        mask8 = 8'h04;
        tick(1);
        mask8 = 8'h00;
        chk("pre_poly_err", 32'(err8), 32'd1);
        poly8 = 2'd0;
        tick(1);
        chk("poly_locked", 32'(locked8), 32'h0);
        chk("poly_valid", 32'(b8.gen_valid), 32'h0);
        chk("poly_keep_err", 32'(err8), 32'd1);
        tick(1);
        chk("poly_first_word", 32'(b8.gen_data), 32'h02);
        tick(8);
        chk("p7w8_before", 32'(locked8), 32'h0);
        tick(1);
        chk("p7w8_lock_9", 32'(locked8), 32'h1);

        // reset mid-lock clears everything
        rst8 = 1'b1;
        tick(1);
        chk("mid_rst_locked", 32'(locked8), 32'h0);
        chk("mid_rst_err", 32'(err8), 32'h0);
        chk("mid_rst_valid", 32'(b8.gen_valid), 32'h0);
        chk("mid_rst_data", 32'(b8.gen_data), 32'h0);
        rst8 = 1'b0;
        tick(1);
        chk("post_rst_word", 32'(b8.gen_data), 32'h02);

`ifdef PRBS_ERR_INJECT_EN
        tick(9);
        chk("inj_locked", 32'(locked8), 32'h1);
        inj8 = 1'b1;
        tick(2);
        chk("inj_flag", 32'(flag8), 32'h1);
        tick(4);
        inj8 = 1'b0;
        tick(2);
        chk("inj_one", 32'(err8), 32'd1);
        chk("inj_still_locked", 32'(locked8), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
